// File: rtl/opm_pkg.sv
// Shared types and default timing for the OPM bus master: FSM states, write command
// layout and strobe timing defaults.
package opm_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSetupA,
    StWrA,
    StGap,
    StSetupD,
    StWrD,
    StBusy,
    StRd,
    StRdDone
  } opm_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } opm_cmd_t;

  localparam int unsigned DefFifoDepth  = 4;
  localparam int unsigned DefWrPulse    = 2;
  localparam int unsigned DefAddrGap    = 4;
  localparam int unsigned DefBusyCycles = 64;
  localparam int unsigned DefRdPulse    = 2;

endpackage

// File: rtl/opm_cmd_fifo.sv
// Synchronous FIFO for {addr, data} write commands.
// A push into a full FIFO is allowed when a pop happens in the same cycle.
module opm_cmd_fifo
  import opm_pkg::*;
#(
  parameter int unsigned Depth = DefFifoDepth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [15:0]   mem_q [Depth];
  logic          push_en, pop_en;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en   = pop && !empty;
  assign push_en  = push && (!full || pop_en);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/opm_bus_master.sv
// Bus master for an OPM sound chip: queues register writes and performs single reads,
// sequencing CS_b/A0/WR_b/RD_b with the chip's address-gap and busy timing.
module opm_bus_master
  import opm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter int unsigned WR_PULSE    = DefWrPulse,
  parameter int unsigned ADDR_GAP    = DefAddrGap,
  parameter int unsigned BUSY_CYCLES = DefBusyCycles,
  parameter int unsigned RD_PULSE    = DefRdPulse
) (
  input  logic       phiM,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [7:0] bus_din,
  input  logic [7:0] bus_dout,
  output logic       bus_a0,
  output logic       bus_cs_b,
  output logic       bus_wr_b,
  output logic       bus_rd_b
);

  opm_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  opm_cmd_t    hold_q, hold_d;
  logic        rd_flag_q, rd_flag_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  rd_data_q;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0] fifo_rdata;
  opm_cmd_t    fifo_cmd;

  assign fifo_cmd  = opm_cmd_t'(fifo_rdata);
  assign cmd_ready = !fifo_full || fifo_pop;
  assign fifo_push = cmd_valid && cmd_ready;
  assign rd_ready  = (state_q == StIdle) && fifo_empty;
  assign rd_valid  = (state_q == StRdDone);
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign rd_data   = rd_data_q;
  assign bus_din   = din_q;

  opm_cmd_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (phiM),
    .rst      (rst),
    .push     (fifo_push),
    .push_data({cmd_addr, cmd_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Counter value loaded on entry: state lasts (value + 1) cycles.
  function automatic logic [7:0] state_len(opm_state_e s);
    logic [7:0] len;
    case (s)
      StWrA, StWrD: len = 8'(WR_PULSE - 1);
      StGap:        len = 8'(ADDR_GAP - 1);
      StBusy:       len = 8'(BUSY_CYCLES - 1);
      StRd:         len = 8'(RD_PULSE - 1);
      default:      len = 8'd0;
    endcase
    return len;
  endfunction

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rd_flag_d = rd_flag_q;
    fifo_pop  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          hold_d    = fifo_cmd;
          rd_flag_d = 1'b0;
          state_d   = StSetupA;
        end else if (rd_req) begin
          hold_d.addr = rd_addr;
          rd_flag_d   = 1'b1;
          state_d     = StSetupA;
        end
      end
      StSetupA: state_d = StWrA;
      StWrA:    if (cnt_q == 8'd0) state_d = StGap;
      StGap:    if (cnt_q == 8'd0) state_d = rd_flag_q ? StRd : StSetupD;
      StSetupD: state_d = StWrD;
      StWrD:    if (cnt_q == 8'd0) state_d = StBusy;
      StBusy:   if (cnt_q == 8'd0) state_d = StIdle;
      StRd:     if (cnt_q == 8'd0) state_d = StRdDone;
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = state_len(state_d);
    else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    else                    cnt_d = cnt_q;

    // Din is loaded on entry to each setup phase and otherwise held.
    case (state_d)
      StSetupA: din_d = hold_d.addr;
      StSetupD: din_d = hold_d.data;
      default:  din_d = din_q;
    endcase
  end

  always_comb begin
    bus_cs_b = 1'b1;
    bus_wr_b = 1'b1;
    bus_rd_b = 1'b1;
    bus_a0   = 1'b0;
    case (state_q)
      StSetupA: bus_cs_b = 1'b0;
      StWrA: begin
        bus_cs_b = 1'b0;
        bus_wr_b = 1'b0;
      end
      StSetupD: begin
        bus_cs_b = 1'b0;
        bus_a0   = 1'b1;
      end
      StWrD: begin
        bus_cs_b = 1'b0;
        bus_a0   = 1'b1;
        bus_wr_b = 1'b0;
      end
      StRd: begin
        bus_cs_b = 1'b0;
        bus_a0   = 1'b1;
        bus_rd_b = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge phiM) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      hold_q    <= '0;
      rd_flag_q <= 1'b0;
      din_q     <= 8'd0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rd_flag_q <= rd_flag_d;
      din_q     <= din_d;
      if (state_q == StRd && cnt_q == 8'd0) rd_data_q <= bus_dout;
    end
  end

endmodule

// File: tb/tb_opm_bus_master.sv
// Scoreboard bench for opm_bus_master: a chip-side monitor/responder checks every bus
// write and read result against expectations queued by the stimulus process.
module tb_opm_bus_master;

  logic       phiM = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_addr, cmd_data;
  logic       cmd_ready;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ready, rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] bus_din, bus_dout;
  logic       bus_a0, bus_cs_b, bus_wr_b, bus_rd_b;

  always #5 phiM = ~phiM;

  opm_bus_master dut (
    .phiM     (phiM),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .bus_a0   (bus_a0),
    .bus_cs_b (bus_cs_b),
    .bus_wr_b (bus_wr_b),
    .bus_rd_b (bus_rd_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge phiM) cyc <= cyc + 1;

  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  int          starts [$];
  int          overlap   = 0;
  int          rd_falls  = 0;
  int          rdv_count = 0;
  int          rdv_cyc   = 0;
  logic [7:0]  regs [256];
  logic [7:0]  cur_addr  = 8'h00;
  logic [7:0]  cur_data  = 8'h00;

  assign bus_dout = regs[cur_addr];

  logic [7:0] ba [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [7:0] bd [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Chip-side monitor and responder.
  initial begin
    logic       prev_wr_b, prev_rd_b, prev_cs_b, prev_a0;
    int         wa_cnt, wd_cnt;
    logic [15:0] e;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    prev_wr_b = 1'b1;
    prev_rd_b = 1'b1;
    prev_cs_b = 1'b1;
    prev_a0   = 1'b0;
    wa_cnt    = 0;
    wd_cnt    = 0;
    forever begin
      @(negedge phiM);
      if (rst) begin
        wa_cnt = 0;
        wd_cnt = 0;
      end else begin
        if (!bus_wr_b && !bus_rd_b) overlap++;
        if (!bus_cs_b && prev_cs_b && !bus_a0) begin
          starts.push_back(cyc);
          wa_cnt = 0;
          wd_cnt = 0;
        end
        if (!bus_rd_b && prev_rd_b) rd_falls++;
        if (!bus_cs_b && !bus_wr_b) begin
          if (!bus_a0) begin
            cur_addr = bus_din;
            wa_cnt++;
          end else begin
            cur_data = bus_din;
            wd_cnt++;
          end
        end
        if (!prev_wr_b && bus_wr_b && prev_a0) begin
          if (exp_wr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got %02h=%02h expected none", cur_addr, cur_data);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", cur_addr, e[15:8]);
            check("wr_data", cur_data, e[7:0]);
            check("wr_addr_pulse", wa_cnt, 2);
            check("wr_data_pulse", wd_cnt, 2);
          end
          regs[cur_addr] = cur_data;
        end
        if (rd_valid) begin
          rdv_count++;
          rdv_cyc = cyc;
          if (exp_rd_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rd_valid: got 0x%0h expected none", rd_data);
          end else begin
            check("rd_data", rd_data, exp_rd_q.pop_front());
          end
        end
      end
      prev_wr_b = bus_wr_b;
      prev_rd_b = bus_rd_b;
      prev_cs_b = bus_cs_b;
      prev_a0   = bus_a0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 300) begin
      @(negedge phiM);
      n++;
    end
    check("push_accept", cmd_ready, 1);
    acc = cyc;
    if (cmd_ready) exp_wr_q.push_back({a, d});
    @(negedge phiM);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge phiM);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_wr_done(input string name, input int bound);
    int n = 0;
    while (exp_wr_q.size() != 0 && n < bound) begin
      @(negedge phiM);
      n++;
    end
    check(name, exp_wr_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc5, rd_acc, n, rf0, rv0, rv_before;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_data  = 8'h00;
    rd_req    = 1'b0;
    rd_addr   = 8'h00;
    repeat (3) @(negedge phiM);

    check("rst_cs_b", bus_cs_b, 1);
    check("rst_wr_b", bus_wr_b, 1);
    check("rst_rd_b", bus_rd_b, 1);
    check("rst_a0", bus_a0, 0);
    check("rst_din", bus_din, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    rst = 1'b0;
    @(negedge phiM);

    // Single write and SETUP_A latency.
    starts.delete();
    push_cmd(8'h20, 8'hC7, acc);
    n = 0;
    while (starts.size() == 0 && n < 20) begin
      @(negedge phiM);
      n++;
    end
    check("setup_a_seen", starts.size(), 1);
    if (starts.size() > 0) check("setup_a_latency", starts[0], acc + 2);
    wait_wr_done("first_write_done", 40);
    check("reg_20", regs[8'h20], 8'hC7);

    // Five pushes while the first write sits in its busy wait.
    for (int i = 0; i < 5; i++) begin
      push_cmd(ba[i], bd[i], acc);
      if (i == 3) check("cmd_ready_full", cmd_ready, 0);
      if (i == 4) acc5 = acc;
    end
    wait_wr_done("batch_writes_done", 600);
    wait_idle("batch_idle", 200);
    check("start_count", starts.size(), 6);
    if (starts.size() == 6) begin
      check("push_pop_when_full", starts[1], acc5 + 1);
      for (int i = 0; i < 5; i++) check("write_spacing", starts[i+1] - starts[i], 75);
    end
    check("reg_05", regs[8'h05], 8'hE5);

    // Write then read back.
    push_cmd(8'h08, 8'h78, acc);
    wait_wr_done("write_08_done", 40);
    wait_idle("write_08_idle", 100);
    rv_before = rdv_count;
    rd_req  = 1'b1;
    rd_addr = 8'h08;
    check("rd_ready_idle", rd_ready, 1);
    exp_rd_q.push_back(8'h78);
    rd_acc = cyc;
    @(negedge phiM);
    rd_req = 1'b0;
    n = 0;
    while (rdv_count == rv_before && n < 30) begin
      @(negedge phiM);
      n++;
    end
    check("rd_valid_count", rdv_count, rv_before + 1);
    check("rd_valid_latency", rdv_cyc, rd_acc + 10);
    @(negedge phiM);
    check("busy_after_read", busy, 0);
    check("rd_data_hold", rd_data, 8'h78);

    // Reads requested while the FIFO is non-empty or the FSM is active are dropped.
    rf0 = rd_falls;
    rv0 = rdv_count;
    push_cmd(8'h30, 8'h11, acc);
    check("rd_ready_fifo_nonempty", rd_ready, 0);
    rd_req  = 1'b1;
    rd_addr = 8'h30;
    @(negedge phiM);
    rd_req = 1'b0;
    repeat (10) @(negedge phiM);
    rd_req = 1'b1;
    @(negedge phiM);
    rd_req = 1'b0;
    wait_wr_done("write_30_done", 40);
    wait_idle("write_30_idle", 100);
    check("ignored_rd_no_strobe", rd_falls, rf0);
    check("ignored_rd_no_valid", rdv_count, rv0);
    check("reg_30", regs[8'h30], 8'h11);

    // Reset during the data strobe aborts the write and flushes the queue.
    push_cmd(8'h40, 8'h55, acc);
    push_cmd(8'h41, 8'h66, acc);
    n = 0;
    while (!(bus_a0 && !bus_wr_b) && n < 40) begin
      @(negedge phiM);
      n++;
    end
    check("reached_wr_d", bus_a0 && !bus_wr_b, 1);
    rst = 1'b1;
    exp_wr_q.delete();
    @(negedge phiM);
    check("abort_cs_b", bus_cs_b, 1);
    check("abort_wr_b", bus_wr_b, 1);
    check("abort_rd_b", bus_rd_b, 1);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    repeat (3) @(negedge phiM);
    check("flushed_busy", busy, 0);
    check("reg_40_untouched", regs[8'h40], 8'h00);
    check("reg_41_untouched", regs[8'h41], 8'h00);
    push_cmd(8'h42, 8'h99, acc);
    wait_wr_done("post_reset_write_done", 40);
    wait_idle("post_reset_idle", 100);
    check("reg_42", regs[8'h42], 8'h99);

    check("no_rd_wr_overlap", overlap, 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
